// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: gathers operand A, operand B and opcode bytes from the UART receiver,
// drives a combinational ALU, then hands the result byte to the UART transmitter.
module uart_alu_ctrl #(
    parameter int N              = 8,
    parameter int OPW            = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   rx_data,
    input  logic           rx_valid,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [N-1:0]   alu_result,
    output logic [N-1:0]   tx_data,
    output logic           tx_start,
    input  logic           tx_busy,
    output logic           op_err,
    output logic           timeout,
    output logic           overrun,
    output logic           ctrl_busy
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_TX_START_WAIT,
        S_TX_DONE_WAIT
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [OPW-1:0] OP_ADD = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SUB = OPW'(6'b100010);
    localparam logic [OPW-1:0] OP_AND = OPW'(6'b100100);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6'b100101);
    localparam logic [OPW-1:0] OP_XOR = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_NOR = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SRA = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_SRL = OPW'(6'b000010);

    state_t         state_q, state_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [N-1:0]   tx_data_q, tx_data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_err_q, op_err_d;
    logic           timeout_q, timeout_d;
    logic           overrun_q, overrun_d;

    logic [OPW-1:0] rx_op;
    logic           op_ok;
    logic           cnt_expired;

    assign rx_op       = rx_data[OPW-1:0];
    assign op_ok       = rx_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                       OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    assign cnt_expired = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_ADD;
            tx_data_q <= '0;
            cnt_q     <= '0;
            op_err_q  <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            op_err_q  <= op_err_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // tx_start is decoded from SEND and the live tx_busy so the request lands in the
    // SEND cycle itself and can never coincide with a busy transmitter.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        op_err_d  = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        tx_start  = 1'b0;

        unique case (state_q)
            S_WAIT_A: begin
                cnt_d = '0;
                if (rx_valid) begin
                    alu_a_d = rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (rx_valid) begin
                    alu_b_d = rx_data;
                    cnt_d   = '0;
                    state_d = S_WAIT_OP;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_OP: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (op_ok) begin
                        alu_op_d = rx_op;
                        state_d  = S_EXEC;
                    end else begin
                        op_err_d = 1'b1;
                        state_d  = S_WAIT_A;
                    end
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                overrun_d = rx_valid;
                tx_data_d = alu_result;
                state_d   = S_SEND;
            end
            S_SEND: begin
                overrun_d = rx_valid;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_TX_START_WAIT;
                end
            end
            S_TX_START_WAIT: begin
                overrun_d = rx_valid;
                if (tx_busy) begin
                    state_d = S_TX_DONE_WAIT;
                end
            end
            S_TX_DONE_WAIT: begin
                overrun_d = rx_valid;
                if (!tx_busy) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_data   = tx_data_q;
    assign op_err    = op_err_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;
    assign ctrl_busy = (state_q != S_WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: random and directed frames checked
// against an arithmetic reference model, with a simple transmitter model.
module tb_uart_alu_ctrl;
    localparam int N   = 8;
    localparam int OPW = 6;
    localparam int T   = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   rx_data = '0;
    logic           rx_valid = 1'b0;
    logic [N-1:0]   alu_a, alu_b, alu_result, tx_data;
    logic [OPW-1:0] alu_op;
    logic           tx_start, tx_busy, op_err, timeout, overrun, ctrl_busy;

    logic           hold_busy = 1'b0;
    logic           xb = 1'b0;
    int             xcnt = 0;
    logic [7:0]     xdata = '0;
    int             xcount = 0;
    logic [5:0]     m_op = 6'h20;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_alu_ctrl #(.N(N), .OPW(OPW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .op_err(op_err), .timeout(timeout), .overrun(overrun), .ctrl_busy(ctrl_busy)
    );

    // Environment ALU driven by the DUT's registered operands.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            6'h03:   alu_result = $signed(alu_a) >>> alu_b;
            6'h02:   alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Transmitter model: busy for 3..8 cycles starting the cycle after tx_start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            xb   <= 1'b0;
            xcnt <= 0;
        end else if (tx_start) begin
            xb     <= 1'b1;
            xcnt   <= $urandom_range(3, 8);
            xdata  <= tx_data;
            xcount <= xcount + 1;
        end else if (xb) begin
            if (xcnt <= 1) xb <= 1'b0;
            xcnt <= xcnt - 1;
        end
    end

    assign tx_busy = xb | hold_busy;

    function automatic bit supported(input logic [5:0] op);
        case (op)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_res(input int a, input int b, input int op);
        int sa;
        case (op)
            32: return (a + b) % 256;
            34: return (a - b + 256) % 256;
            36: return a & b;
            37: return a | b;
            38: return a ^ b;
            39: return 255 - (a | b);
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                if (b >= 8) sa = (sa < 0) ? -1 : 0;
                else sa = sa >>> b;
                return sa & 255;
            end
            2: return (b >= 8) ? 0 : (a >> b);
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        logic [34:0] rv;
        rv = {8'h00, 8'h00, 6'h20, 8'h00, 5'b00000};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy} !== rv) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h",
                     {alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy}, rv);
        end
        reset = 1'b0;
        m_op  = 6'h20;
        repeat (2 * T) tick();
        @(negedge clk);
        checks++;
        if ({timeout, ctrl_busy, tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL idle_wait_a: got timeout/busy/start=%b expected 000", {timeout, ctrl_busy, tx_start});
        end
    endtask

    task automatic test_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input int gap, input int hold, input bit ovr);
        logic [5:0] op;
        logic [7:0] exp;
        int xc0, busy_cyc;
        bit done, inj, pend, pend_now;
        op  = opb[5:0];
        xc0 = xcount;
        exp = 8'(model_res(int'(a), int'(b), int'(op)));
        send_byte(a);
        repeat (gap) tick();
        send_byte(b);
        repeat (gap) tick();
        if (hold > 0) hold_busy = 1'b1;
        send_byte(opb);
        @(negedge clk);
        if (!supported(op)) begin
            checks++;
            if ({op_err, ctrl_busy, tx_start} !== 3'b100) begin
                errors++;
                $display("FAIL op_err_cycle: got err/busy/start=%b expected 100", {op_err, ctrl_busy, tx_start});
            end
            checks++;
            if (alu_op !== m_op) begin
                errors++;
                $display("FAIL alu_op_kept: got %h expected %h", alu_op, m_op);
            end
            tick();
            @(negedge clk);
            checks++;
            if (op_err !== 1'b0 || xcount != xc0) begin
                errors++;
                $display("FAIL op_err_after: got op_err=%b starts=%0d expected 0 and %0d", op_err, xcount, xc0);
            end
            hold_busy = 1'b0;
            return;
        end
        m_op = op;
        checks++;
        if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin
            errors++;
            $display("FAIL operands: got %h %h %h expected %h %h %h", alu_a, alu_b, alu_op, a, b, op);
        end
        checks++;
        if ({ctrl_busy, tx_start, op_err, timeout, overrun} !== 5'b10000) begin
            errors++;
            $display("FAIL exec_flags: got busy/start/err/to/ovr=%b expected 10000",
                     {ctrl_busy, tx_start, op_err, timeout, overrun});
        end
        tick();
        @(negedge clk);
        checks++;
        if (tx_data !== exp) begin
            errors++;
            $display("FAIL tx_data: got %h expected %h (a=%h b=%h op=%h)", tx_data, exp, a, b, op);
        end
        for (int j = 0; j < hold; j++) begin
            checks++;
            if (tx_start !== 1'b0) begin
                errors++;
                $display("FAIL tx_start_held: got %b expected 0 while tx_busy held", tx_start);
            end
            tick();
            if (j == hold - 1) hold_busy = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL tx_start: got %b expected 1", tx_start);
        end
        done = 0; inj = 0; pend = 0; pend_now = 0; busy_cyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            rx_valid = 1'b0;
            if (ovr && busy_cyc == 1 && !inj) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                inj      = 1;
                pend_now = 1;
            end
            @(negedge clk);
            checks++;
            if (tx_start !== 1'b0 || overrun !== pend) begin
                errors++;
                $display("FAIL tx_phase: got start=%b overrun=%b expected 0 and %b", tx_start, overrun, pend);
            end
            pend = pend_now;
            pend_now = 0;
            if (tx_busy) begin
                busy_cyc++;
            end else if (busy_cyc > 0) begin
                checks++;
                if (ctrl_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_fall_cycle: got ctrl_busy=%b expected 1", ctrl_busy);
                end
                tick();
                @(negedge clk);
                checks++;
                if (ctrl_busy !== 1'b0 || xdata !== exp || xcount != xc0 + 1) begin
                    errors++;
                    $display("FAIL frame_end: got busy=%b sent=%h starts=%0d expected 0 %h %0d",
                             ctrl_busy, xdata, xcount, exp, xc0 + 1);
                end
                done = 1;
            end
        end
        rx_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL tx_wait: transmit handshake did not complete within 40 cycles");
        end
    endtask

    task automatic test_directed();
        test_frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
        test_frame(8'h03, 8'h05, 8'h22, 1, 0, 0);
        test_frame(8'h80, 8'h02, 8'h03, 0, 0, 0);
        test_frame(8'h80, 8'h02, 8'h02, 0, 0, 0);
        test_frame(8'h11, 8'h22, 8'h3F, 0, 0, 0);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        repeat (T - 1) tick();
        @(negedge clk);
        checks++;
        if ({timeout, ctrl_busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_b_early: got to/busy=%b expected 01", {timeout, ctrl_busy});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({timeout, ctrl_busy, alu_a} !== {2'b10, 8'hA5}) begin
            errors++;
            $display("FAIL timeout_b: got to/busy=%b a=%h expected 10 a5", {timeout, ctrl_busy}, alu_a);
        end
        tick();
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got %b expected 0", timeout);
        end
        test_frame(8'h01, 8'h01, 8'h20, 0, 0, 0);
        send_byte(8'h5A);
        send_byte(8'hC3);
        repeat (T - 1) tick();
        tick();
        @(negedge clk);
        checks++;
        if ({timeout, ctrl_busy, alu_b} !== {2'b10, 8'hC3}) begin
            errors++;
            $display("FAIL timeout_op: got to/busy=%b b=%h expected 10 c3", {timeout, ctrl_busy}, alu_b);
        end
        test_frame(8'h01, 8'h01, 8'h20, 0, 0, 0);
        test_frame(8'h37, 8'h19, 8'h26, T - 1, 0, 0);
    endtask

    task automatic test_overrun_and_hold();
        test_frame(8'h44, 8'h0F, 8'h24, 0, 0, 1);
        test_frame(8'hF0, 8'h0F, 8'h27, 0, 4, 0);
        test_frame(8'h9C, 8'h03, 8'h03, 2, 1, 1);
    endtask

    task automatic test_random();
        logic [5:0] tbl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        logic [7:0] a, b, opb;
        logic [5:0] op6;
        int k, gap, hold;
        for (int i = 0; i < 30; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 9));
            k   = $urandom_range(0, 9);
            op6 = (k < 8) ? tbl[k] : 6'($urandom);
            opb = {2'($urandom), op6};
            gap = ($urandom_range(0, 4) == 0) ? T - 1 : $urandom_range(0, 2);
            hold = supported(op6) ? $urandom_range(0, 3) : 0;
            test_frame(a, b, opb, gap, hold, 1'($urandom));
        end
    endtask

    task automatic test_reset_midframe();
        logic [34:0] rv;
        rv = {8'h00, 8'h00, 6'h20, 8'h00, 5'b00000};
        test_frame(8'h09, 8'h04, 8'h22, 0, 0, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy} !== rv) begin
            errors++;
            $display("FAIL reset_wait_op: got %h expected %h",
                     {alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy}, rv);
        end
        m_op = 6'h20;
        tick();
        reset = 1'b0;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({ctrl_busy, tx_busy} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_tdw: got busy/tx_busy=%b expected 11", {ctrl_busy, tx_busy});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy} !== rv) begin
            errors++;
            $display("FAIL reset_tx_done: got %h expected %h",
                     {alu_a, alu_b, alu_op, tx_data, tx_start, op_err, timeout, overrun, ctrl_busy}, rv);
        end
        m_op = 6'h20;
        tick();
        reset = 1'b0;
        test_frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
        test_frame(8'h11, 8'h22, 8'h3F, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_overrun_and_hold();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencing controller between the UART receiver, a combinational ALU and the UART transmitter. It collects three received bytes (operand A, operand B, opcode), drives the ALU operands and opcode from registers, and captures the result. It then launches one transmit of the result byte and waits for the transmitter to finish. An inter-byte timeout recovers from lost bytes, and pulse flags report invalid opcodes and dropped bytes.

## Interface
- N, 8, data/operand width; equals UART data width.
- OPW, 6, opcode width; opcode is taken from rx_data[OPW-1:0].
- TIMEOUT_CYCLES, 5000000, maximum clk cycles allowed between bytes of one frame; must be ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- rx_data  in  N  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received byte.
- alu_a  out  N  registered operand A.
- alu_b  out  N  registered operand B.
- alu_op  out  OPW  registered opcode.
- alu_result  in  N  combinational ALU output for alu_a/alu_b/alu_op.
- tx_data  out  N  registered byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy; high from the cycle after tx_start until its stop bit completes.
- op_err  out  1  one-cycle pulse: received opcode not supported.
- timeout  out  1  one-cycle pulse: frame abandoned by timeout.
- overrun  out  1  one-cycle pulse: rx_valid arrived while not accepting bytes.
- ctrl_busy  out  1  high in every state except WAIT_A.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, TX_START_WAIT, TX_DONE_WAIT.
- WAIT_A: rx_valid=1 → alu_a<=rx_data, go to WAIT_B.
- WAIT_B: rx_valid=1 → alu_b<=rx_data, go to WAIT_OP.
- WAIT_OP: rx_valid=1 → check rx_data[OPW-1:0].
  - Supported opcode → alu_op<=opcode, go to EXEC.
  - Otherwise → op_err pulse, alu_op unchanged, go to WAIT_A.
- Supported opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
- EXEC: tx_data<=alu_result, go to SEND. ALU result width is N; carry and overflow are discarded.
- SEND: if tx_busy=0 → tx_start=1 for this cycle, go to TX_START_WAIT. If tx_busy=1 → stay in SEND, tx_start=0.
- TX_START_WAIT: tx_busy=1 → go to TX_DONE_WAIT.
- TX_DONE_WAIT: tx_busy=0 → go to WAIT_A.
- Timeout counter:
  - Cleared on every accepted byte and on entry to WAIT_A.
  - Increments each cycle in WAIT_B and WAIT_OP.
  - Reaching TIMEOUT_CYCLES-1 with no rx_valid in that cycle → timeout pulse, go to WAIT_A; alu_a/alu_b keep stale values.
  - rx_valid in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- rx_valid in EXEC, SEND, TX_START_WAIT or TX_DONE_WAIT → byte dropped, overrun pulse, no state change.

## Timing
- Reset values:
  - State WAIT_A; alu_a, alu_b, tx_data = 0; alu_op = 6'b100000.
  - tx_start, op_err, timeout, overrun, ctrl_busy = 0; timeout counter = 0.
- Reset mid-frame or mid-transmit: immediate return to reset values. The transmitter is reset by the same signal.
- Outputs are registered. Register updates are visible the cycle after the accepting rx_valid.
- Latency from opcode rx_valid (cycle t) to transmit request:
  - alu_op valid at t+1 (EXEC).
  - tx_data valid at t+2 (SEND).
  - tx_start high during cycle t+2 if tx_busy=0.
- tx_start is never high for two consecutive cycles and is never asserted while tx_busy=1.
- A new frame's byte A is accepted at the earliest in the cycle after tx_busy falls.
- ctrl_busy is combinational from the state register only.

## Test plan
- Reset, then send A=0x05, B=0x03, op=0x20 → tx_start single pulse with tx_data=0x08 two cycles after the op byte; return to WAIT_A after tx_busy falls.
- A=0x03, B=0x05, SUB (0x22) → tx_data=0xFE. A=0x80, B=0x02, SRA (0x03) → tx_data=0xE0. SRL (0x02) with the same operands → tx_data=0x20.
- A=0x11, B=0x22, op=0x3F → op_err pulse for one cycle, no tx_start, ctrl_busy=0 the next cycle.
- A only, then silence for TIMEOUT_CYCLES (bench sets 16) → timeout pulse; next three bytes 0x01, 0x01, 0x20 → tx_data=0x02. Also: a byte arriving exactly in the expiry cycle is accepted with no timeout.
- rx_valid pulse during TX_DONE_WAIT → overrun pulse, transmitted result unchanged, state unchanged. tx_busy held high in SEND → tx_start withheld until tx_busy=0.
- Reset asserted while in WAIT_OP and again in TX_DONE_WAIT → all outputs at reset values in the same cycle; a full frame afterwards transmits correctly.
